// File: rtl/eco32_core_ifu_pkg.sv
// Shared IFU definitions: refill FSM state encoding and line geometry.
package eco32_core_ifu_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] FILL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int LINE_WORDS = 8;
    localparam int NUM_TID    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_REQ  = REQ,
        ST_FILL = FILL,
        ST_DONE = DONE
    } refill_state_e;

endpackage

// File: rtl/eco32_core_ifu_icu_rr_arb.sv
// Two-input round-robin arbiter; the pointer flips to the other tid after every grant.
module eco32_core_ifu_icu_rr_arb
    import eco32_core_ifu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_TID-1:0] req,
    input  logic               take,
    output logic               gnt_vld,
    output logic               gnt_tid
);

    logic rr;

    always_comb begin
        gnt_vld = |req;
        gnt_tid = (&req) ? rr : req[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr <= 1'b0;
        else if (take && gnt_vld)
            rr <= ~gnt_tid;
    end

endmodule

// File: rtl/eco32_core_ifu_icu_refill_ctl.sv
// I-cache line refill controller: arbitrates thread misses, issues one line read, streams 8 beats
// into the way memory. ECO32_ICU_CRITICAL_WORD_FIRST_EN starts the fill at the missed word.
module eco32_core_ifu_icu_refill_ctl
    import eco32_core_ifu_pkg::*;
#(
    parameter int PAGE_ADDR_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   miss_req,
    input  logic [2*PAGE_ADDR_WIDTH-1:0] miss_page,
    input  logic [5:0]                   miss_offset,
    output logic [1:0]                   miss_done,
    output logic                         mem_rd_req,
    output logic                         mem_rd_tid,
    output logic [PAGE_ADDR_WIDTH-1:0]   mem_rd_page,
    output logic [2:0]                   mem_rd_offset,
    input  logic                         mem_rd_ack,
    input  logic                         mem_rd_vld,
    input  logic [71:0]                  mem_rd_data,
    output logic                         wr_ena,
    output logic                         wr_tid,
    output logic [PAGE_ADDR_WIDTH-1:0]   wr_page,
    output logic [2:0]                   wr_offset,
    output logic [71:0]                  wr_data,
    output logic                         o_busy
);

    refill_state_e              state, state_nxt;
    logic                       gnt_vld, gnt_tid;
    logic                       cur_tid;
    logic [PAGE_ADDR_WIDTH-1:0] cur_page;
    logic [2:0]                 start_off, start_off_nxt;
    logic [2:0]                 beat_cnt;
    logic                       last_beat;
    logic                       beat;

    eco32_core_ifu_icu_rr_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (miss_req),
        .take    (state == ST_IDLE),
        .gnt_vld (gnt_vld),
        .gnt_tid (gnt_tid)
    );

`ifdef ECO32_ICU_CRITICAL_WORD_FIRST_EN
    assign start_off_nxt = gnt_tid ? miss_offset[5:3] : miss_offset[2:0];
`else
    logic unused_miss_offset;
    assign unused_miss_offset = ^miss_offset;
    assign start_off_nxt      = 3'd0;
`endif

    assign last_beat = (beat_cnt == 3'(LINE_WORDS - 1));
    assign beat      = (state == ST_FILL) && mem_rd_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (gnt_vld)            state_nxt = ST_REQ;
            ST_REQ:  if (mem_rd_ack)         state_nxt = ST_FILL;
            ST_FILL: if (beat && last_beat)  state_nxt = ST_DONE;
            ST_DONE:                         state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    // Grant context is captured once in IDLE; later changes on miss_* cannot disturb the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_tid   <= 1'b0;
            cur_page  <= '0;
            start_off <= 3'd0;
            beat_cnt  <= 3'd0;
        end else begin
            if (state == ST_IDLE && gnt_vld) begin
                cur_tid   <= gnt_tid;
                cur_page  <= gnt_tid ? miss_page[2*PAGE_ADDR_WIDTH-1:PAGE_ADDR_WIDTH]
                                     : miss_page[PAGE_ADDR_WIDTH-1:0];
                start_off <= start_off_nxt;
            end
            if (state == ST_REQ && mem_rd_ack)
                beat_cnt <= 3'd0;
            else if (beat)
                beat_cnt <= beat_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ena    <= 1'b0;
            wr_tid    <= 1'b0;
            wr_page   <= '0;
            wr_offset <= 3'd0;
            wr_data   <= '0;
        end else begin
            wr_ena <= beat;
            if (beat) begin
                wr_tid    <= cur_tid;
                wr_page   <= cur_page;
                wr_offset <= start_off + beat_cnt;
                wr_data   <= mem_rd_data;
            end
        end
    end

    // DONE is entered on the edge that also registers the 8th write, so both appear together.
    assign miss_done     = (state == ST_DONE) ? (cur_tid ? 2'b10 : 2'b01) : 2'b00;
    assign mem_rd_req    = (state == ST_REQ);
    assign mem_rd_tid    = cur_tid;
    assign mem_rd_page   = cur_page;
    assign mem_rd_offset = start_off;
    assign o_busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_eco32_core_ifu_icu_refill_ctl.sv
// Scoreboard bench for the I-cache refill controller: memory responder pushes expected writes,
// a monitor pops and compares them whenever the DUT writes.
`timescale 1ns/1ps
module tb_eco32_core_ifu_icu_refill_ctl;

    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    miss_req;
    logic [2*PW-1:0] miss_page;
    logic [5:0]    miss_offset;
    logic [1:0]    miss_done;
    logic          mem_rd_req, mem_rd_tid;
    logic [PW-1:0] mem_rd_page;
    logic [2:0]    mem_rd_offset;
    logic          mem_rd_ack, mem_rd_vld;
    logic [71:0]   mem_rd_data;
    logic          wr_ena, wr_tid;
    logic [PW-1:0] wr_page;
    logic [2:0]    wr_offset;
    logic [71:0]   wr_data;
    logic          o_busy;

    always #5 clk = ~clk;

    eco32_core_ifu_icu_refill_ctl #(.PAGE_ADDR_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_req(miss_req), .miss_page(miss_page), .miss_offset(miss_offset),
        .miss_done(miss_done),
        .mem_rd_req(mem_rd_req), .mem_rd_tid(mem_rd_tid), .mem_rd_page(mem_rd_page),
        .mem_rd_offset(mem_rd_offset), .mem_rd_ack(mem_rd_ack), .mem_rd_vld(mem_rd_vld),
        .mem_rd_data(mem_rd_data),
        .wr_ena(wr_ena), .wr_tid(wr_tid), .wr_page(wr_page), .wr_offset(wr_offset),
        .wr_data(wr_data), .o_busy(o_busy)
    );

    typedef struct {
        logic          tid;
        logic [PW-1:0] page;
        logic [2:0]    off;
        logic [71:0]   data;
        logic          done;
    } wr_exp_t;

    typedef struct {
        logic          tid;
        logic [PW-1:0] page;
        logic [2:0]    off;
    } rd_exp_t;

    wr_exp_t sb_q[$];
    rd_exp_t rd_q[$];

    int n_chk = 0, n_fail = 0;
    int wr_cnt = 0, done_cnt = 0;
    int ack_delay = 0, gap_max = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] start_of(input logic [2:0] off);
`ifdef ECO32_ICU_CRITICAL_WORD_FIRST_EN
        return off;
`else
        return 3'd0;
`endif
    endfunction

    function automatic logic [71:0] beat_data(input logic tid, input logic [PW-1:0] page, input int i);
        return {4'hA, 8'(8'hD0 + i), 3'b0, tid, 3'b0, page, 32'h1234_0000 + 32'(i), 16'hBEEF};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue(input logic tid, input logic [PW-1:0] page, input logic [2:0] off);
        miss_page[tid*PW +: PW]  = page;
        miss_offset[tid*3 +: 3]  = off;
        rd_q.push_back('{tid, page, off});
        miss_req[tid] = 1'b1;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k = 0;
        while (done_cnt < target && k < budget) begin cyc(1); k++; end
        chk(name, done_cnt, target);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_miss_done"},  miss_done, 0);
        chk({tag, "_mem_rd_req"}, mem_rd_req, 0);
        chk({tag, "_rd_page"},    mem_rd_page, 0);
        chk({tag, "_rd_offset"},  mem_rd_offset, 0);
        chk({tag, "_wr_ena"},     wr_ena, 0);
        chk({tag, "_wr_offset"},  wr_offset, 0);
        chk({tag, "_wr_data"},    wr_data, 0);
        chk({tag, "_busy"},       o_busy, 0);
    endtask

    // Requester: drops miss_req once its line has been reported complete.
    initial forever begin
        @(negedge clk);
        for (int t = 0; t < 2; t++)
            if (miss_done[t] === 1'b1) miss_req[t] = 1'b0;
    end

    // Monitor: every write must match the next expected beat.
    initial forever begin
        wr_exp_t e;
        @(negedge clk);
        if (wr_ena === 1'b1) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                chk("write_without_beat", wr_ena, 0);
            end else begin
                e = sb_q.pop_front();
                chk("wr_tid",    wr_tid, e.tid);
                chk("wr_page",   wr_page, e.page);
                chk("wr_offset", wr_offset, e.off);
                chk("wr_data",   wr_data, e.data);
                chk("miss_done", miss_done, e.done ? (e.tid ? 2'b10 : 2'b01) : 2'b00);
                if (e.done) done_cnt++;
            end
        end else if (miss_done !== 2'b00 && rst_n) begin
            chk("done_without_write", miss_done, 0);
        end
    end

    // Memory responder: checks the read request, acks, returns 8 beats, records expectations.
    initial begin
        rd_exp_t     r;
        logic [2:0]  so;
        int          g;
        mem_rd_ack = 1'b0; mem_rd_vld = 1'b0; mem_rd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && mem_rd_req === 1'b1) begin
                if (rd_q.size() == 0) begin
                    chk("rd_req_unexpected", mem_rd_req, 0);
                    r = '{1'b0, '0, 3'd0};
                end else begin
                    r = rd_q.pop_front();
                end
                so = start_of(r.off);
                chk("rd_tid",    mem_rd_tid, r.tid);
                chk("rd_page",   mem_rd_page, r.page);
                chk("rd_offset", mem_rd_offset, so);
                for (int k = 0; k < ack_delay && rst_n; k++) begin @(posedge clk); #1; end
                if (!rst_n) continue;
                mem_rd_ack = 1'b1;
                @(posedge clk); #1;
                mem_rd_ack = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
                    for (int k = 0; k < g && rst_n; k++) begin @(posedge clk); #1; end
                    if (!rst_n) break;
                    mem_rd_vld  = 1'b1;
                    mem_rd_data = beat_data(r.tid, r.page, i);
                    sb_q.push_back('{r.tid, r.page, 3'(so + 3'(i)), mem_rd_data, (i == 7)});
                    @(posedge clk); #1;
                    mem_rd_vld = 1'b0;
                    if (!rst_n) break;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w0, d0, k;
        miss_req = 2'b00; miss_page = '0; miss_offset = '0;
        #12;
        chk_outputs_zero("reset");
        @(posedge clk); #1; rst_n = 1'b1;
        cyc(2);

        // Single miss, tid0, page 5, offset 3, back-to-back beats.
        issue(1'b0, 5'd5, 3'd3);
        chk("idle_busy", o_busy, 0);
        cyc(1);
        chk("rd_req_latency", mem_rd_req, 1);
        chk("req_busy", o_busy, 1);
        wait_done(1, 100, "t1_done");
        cyc(2);

        // Double request from reset: tid0, tid1, then tid0 first again.
        rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(1);
        issue(1'b0, 5'd10, 3'd1);
        issue(1'b1, 5'd20, 3'd6);
        wait_done(3, 200, "t3_pair1_done");
        cyc(2);
        issue(1'b0, 5'd7, 3'd2);
        issue(1'b1, 5'd8, 3'd5);
        wait_done(5, 200, "t3_pair2_done");
        cyc(2);

        // Delayed ack and gapped beats, then a stray beat in IDLE.
        ack_delay = 5; gap_max = 3;
        w0 = wr_cnt;
        issue(1'b1, 5'd17, 3'd4);
        wait_done(6, 300, "t4_done");
        chk("t4_write_count", wr_cnt - w0, 8);
        ack_delay = 0; gap_max = 0;
        cyc(3);
        w0 = wr_cnt;
        mem_rd_vld = 1'b1; mem_rd_data = {72{1'b1}};
        cyc(1);
        mem_rd_vld = 1'b0;
        cyc(1);
        chk("stray_vld_wr_ena", wr_ena, 0);
        chk("stray_vld_wr_cnt", wr_cnt, w0);

        // Reset after 4 beats of a fill.
        w0 = wr_cnt;
        d0 = done_cnt;
        issue(1'b0, 5'd3, 3'd5);
        k = 0;
        while (wr_cnt < w0 + 4 && k < 100) begin @(negedge clk); #1; k++; end
        chk("rst_fill_progress", (wr_cnt - w0) >= 4, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        sb_q.delete();
        miss_req = 2'b00;
        cyc(3);
        rst_n = 1'b1;
        cyc(4);
        chk("post_rst_busy", o_busy, 0);
        chk("post_rst_no_done", done_cnt, d0);
        chk("post_rst_wr_ena", wr_ena, 0);

        // Top page, last offset.
        issue(1'b1, 5'd31, 3'd7);
        wait_done(d0 + 1, 100, "t6_done");
        cyc(3);
        chk("sb_drained", sb_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
